// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: blank pattern, glyph constants and a
// hex-to-glyph helper. Every pattern is active-low, packed as {g,f,e,d,c,b,a}.
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  // All segments off.
  localparam seg_t SEG_BLANK = 7'h7F;

  // Decimal digits.
  localparam seg_t SEG_0 = 7'h40;
  localparam seg_t SEG_1 = 7'h79;
  localparam seg_t SEG_2 = 7'h24;
  localparam seg_t SEG_3 = 7'h30;
  localparam seg_t SEG_4 = 7'h19;
  localparam seg_t SEG_5 = 7'h12;
  localparam seg_t SEG_6 = 7'h02;
  localparam seg_t SEG_7 = 7'h78;
  localparam seg_t SEG_8 = 7'h00;
  localparam seg_t SEG_9 = 7'h10;

  // Hex letters (b and d are lower-case shapes so they differ from 8 and 0).
  localparam seg_t SEG_A = 7'h08;
  localparam seg_t SEG_B = 7'h03;
  localparam seg_t SEG_C = 7'h46;
  localparam seg_t SEG_D = 7'h21;
  localparam seg_t SEG_E = 7'h06;
  localparam seg_t SEG_F = 7'h0E;

  // Extra letters used by client status messages.
  localparam seg_t SEG_R    = 7'h2F;  // r
  localparam seg_t SEG_G    = 7'h42;  // G
  localparam seg_t SEG_LC_B = 7'h03;  // b
  localparam seg_t SEG_LC_N = 7'h2B;  // n
  localparam seg_t SEG_P    = 7'h0C;  // P
  localparam seg_t SEG_LC_D = 7'h21;  // d
  localparam seg_t SEG_DASH = 7'h3F;  // '-'

  // Map a nibble to its active-low hex glyph.
  function automatic seg_t hex_to_seg(input logic [3:0] v);
    seg_t s;
    case (v)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      default: s = SEG_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seven_seg_timebase.sv
// Scan timebase: slot prescaler, digit index, frame boundary and the blink
// phase derived from a frame counter.
module seven_seg_timebase
  import seven_seg_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int DIV_W        = 17,
  parameter int BLINK_FRAMES = 64,
  parameter int IDX_W        = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [DIV_W-1:0] cnt,
  output logic [IDX_W-1:0] idx,
  output logic             frame_end,
  output logic             phase
);

  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic            slot_end;
  logic            last_idx;
  logic [FC_W-1:0] fcnt;

  // Slot and frame boundaries decoded from the current count.
  always_comb begin
    slot_end  = &cnt;
    last_idx  = (idx == IDX_W'(N_DIGITS - 1));
    frame_end = slot_end && last_idx;
  end

  // Free-running slot prescaler; wraps naturally at 2^DIV_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

  // Digit index steps at the end of each slot and wraps after the last digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else if (slot_end) begin
      idx <= last_idx ? '0 : idx + IDX_W'(1);
    end
  end

  // Frame counter; phase flips every BLINK_FRAMES frames (phase 0 = visible).
  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt  <= '0;
      phase <= 1'b0;
    end else if (frame_end) begin
      if (fcnt == FC_W'(BLINK_FRAMES - 1)) begin
        fcnt  <= '0;
        phase <= ~phase;
      end else begin
        fcnt <= fcnt + FC_W'(1);
      end
    end
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode seven-segment driver with tear-free double
// buffering, per-digit decimal point and blink, brightness duty control and a
// one-cycle anti-ghost blanking guard at the start of every digit slot.
//
// load protocol: load is a single-cycle strobe with no back-pressure. The
// glyph/dp_in/blink values present in that cycle are captured into staging and
// promoted to the displayed set at the next frame boundary; a later load before
// that boundary replaces the staged values. A load in the boundary cycle itself
// goes straight to the displayed set.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int DIV_W        = 17,
  parameter int BRIGHT_W     = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7*N_DIGITS-1:0]   glyph,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic [N_DIGITS-1:0]     blink,
  input  logic                    load,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [N_DIGITS-1:0]     an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_tick
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [7*N_DIGITS-1:0] GLYPHS_BLANK = {N_DIGITS{SEG_BLANK}};

  logic [DIV_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic                  frame_end;
  logic                  phase;

  logic [7*N_DIGITS-1:0] stage_glyph;
  logic [N_DIGITS-1:0]   stage_dp;
  logic [N_DIGITS-1:0]   stage_blink;
  logic                  pending;

  logic [7*N_DIGITS-1:0] act_glyph;
  logic [N_DIGITS-1:0]   act_dp;
  logic [N_DIGITS-1:0]   act_blink;

  logic                  suppressed;
  logic                  bright_ok;
  logic                  lit;
  logic [N_DIGITS-1:0]   an_sel;
  logic [6:0]            seg_sel;
  logic                  dp_sel;

  seven_seg_timebase #(
    .N_DIGITS     (N_DIGITS),
    .DIV_W        (DIV_W),
    .BLINK_FRAMES (BLINK_FRAMES),
    .IDX_W        (IDX_W)
  ) u_timebase (
    .clk       (clk),
    .rst       (rst),
    .cnt       (cnt),
    .idx       (idx),
    .frame_end (frame_end),
    .phase     (phase)
  );

  // Staging buffer: every load overwrites it, so the last load before a frame
  // boundary is the one that gets displayed.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_glyph <= GLYPHS_BLANK;
      stage_dp    <= '0;
      stage_blink <= '0;
    end else if (load) begin
      stage_glyph <= glyph;
      stage_dp    <= dp_in;
      stage_blink <= blink;
    end
  end

  // Displayed buffer only changes on a frame boundary, so a frame never tears.
  // A load landing on the boundary bypasses staging and clears pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_glyph <= GLYPHS_BLANK;
      act_dp    <= '0;
      act_blink <= '0;
      pending   <= 1'b0;
    end else if (frame_end && load) begin
      act_glyph <= glyph;
      act_dp    <= dp_in;
      act_blink <= blink;
      pending   <= 1'b0;
    end else if (frame_end && pending) begin
      act_glyph <= stage_glyph;
      act_dp    <= stage_dp;
      act_blink <= stage_blink;
      pending   <= 1'b0;
    end else if (load) begin
      pending <= 1'b1;
    end
  end

  // Decide whether the current digit is driven this cycle and what it shows.
  // cnt == 0 is always dark so the previous digit's segments never bleed into
  // the next anode; brightness compares against the top bits of cnt.
  always_comb begin
    suppressed = act_blink[idx] && phase;
    bright_ok  = (cnt[DIV_W-1 -: BRIGHT_W] <= brightness);
    lit        = (cnt != '0) && bright_ok && !suppressed;
    an_sel     = ~(N_DIGITS'(1) << idx);
    seg_sel    = act_glyph[7*int'(idx) +: 7];
    dp_sel     = ~act_dp[idx];
  end

  // Registered pin drivers: one cycle behind cnt/idx, all dark when not lit.
  always_ff @(posedge clk) begin
    if (rst) begin
      an         <= '1;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_end;
      if (lit) begin
        an  <= an_sel;
        seg <= seg_sel;
        dp  <= dp_sel;
      end else begin
        an  <= '1;
        seg <= SEG_BLANK;
        dp  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with N_DIGITS=4, DIV_W=4, BRIGHT_W=2,
// BLINK_FRAMES=2. A slot is 16 cycles, a frame 64 cycles. The variable t is
// the scan time whose cnt/idx the registered outputs currently reflect:
// cnt = t % 16, digit = (t / 16) % 4, frame = t / 64, counted from the last
// reset release.
module tb_seven_seg_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [27:0] glyph = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blink = '0;
  logic        load = 1'b0;
  logic [1:0]  brightness = 2'd3;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  int checks = 0;
  int failures = 0;
  int t = 0;
  int multi_low = 0;
  int lit_cnt [4];

  seven_seg_scan #(
    .N_DIGITS     (4),
    .DIV_W        (4),
    .BRIGHT_W     (2),
    .BLINK_FRAMES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .glyph      (glyph),
    .dp_in      (dp_in),
    .blink      (blink),
    .load       (load),
    .brightness (brightness),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  // Clock: 10 time-unit period, first rising edge at 5.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  // Compare the pin group as {an, seg, dp}.
  task automatic chk_pins(input string tag, input logic [3:0] e_an,
                          input logic [6:0] e_seg, input logic e_dp);
    chk(tag, {20'd0, an, seg, dp}, {20'd0, e_an, e_seg, e_dp});
  endtask

  // Advance n clocks, sampling on the falling edge; also watch for more than
  // one anode driven at once.
  task automatic adv(input int n);
    repeat (n) begin
      @(negedge clk);
      t++;
      if ($countones(~an) > 1) multi_low++;
    end
  endtask

  task automatic goto(input int target);
    adv(target - t);
  endtask

  // Run one full frame and tally the lit cycles per digit.
  task automatic count_frame();
    for (int d = 0; d < 4; d++) lit_cnt[d] = 0;
    repeat (64) begin
      adv(1);
      for (int d = 0; d < 4; d++) begin
        if (an == ~(4'b0001 << d)) lit_cnt[d]++;
      end
    end
  endtask

  task automatic chk_counts(input string tag, input int e0, input int e1,
                            input int e2, input int e3);
    chk({tag, "_d0"}, lit_cnt[0], e0);
    chk({tag, "_d1"}, lit_cnt[1], e1);
    chk({tag, "_d2"}, lit_cnt[2], e2);
    chk({tag, "_d3"}, lit_cnt[3], e3);
  endtask

  initial begin
    // Reset held for three rising edges.
    repeat (3) @(negedge clk);
    chk_pins("rst_pins", 4'hF, 7'h7F, 1'b1);
    chk("rst_frame_tick", frame_tick, 1'b0);
    rst = 1'b0;
    t = -1;
    adv(1);
    chk_pins("first_guard", 4'hF, 7'h7F, 1'b1);
    adv(1);
    chk_pins("first_lit", 4'hE, 7'h7F, 1'b1);
    chk("first_ft", frame_tick, 1'b0);

    // Mid-frame load: nothing changes until the frame boundary.
    goto(20);
    glyph = {7'h30, 7'h24, 7'h79, 7'h40};
    load = 1'b1;
    adv(1);
    load = 1'b0;
    goto(33);
    chk_pins("no_tear", 4'hB, 7'h7F, 1'b1);
    goto(62);
    chk("ft_before", frame_tick, 1'b0);
    adv(1);
    chk("ft_at_63", frame_tick, 1'b1);
    chk_pins("old_last_slot", 4'h7, 7'h7F, 1'b1);
    adv(1);
    chk_pins("guard_64", 4'hF, 7'h7F, 1'b1);
    chk("ft_after", frame_tick, 1'b0);
    adv(1);
    chk_pins("d0_start", 4'hE, 7'h40, 1'b1);
    goto(79);
    chk_pins("d0_end", 4'hE, 7'h40, 1'b1);
    adv(1);
    chk_pins("guard_80", 4'hF, 7'h7F, 1'b1);
    adv(1);
    chk_pins("d1_start", 4'hD, 7'h79, 1'b1);
    goto(97);
    chk_pins("d2_start", 4'hB, 7'h24, 1'b1);
    goto(113);
    chk_pins("d3_start", 4'h7, 7'h30, 1'b1);
    goto(127);
    chk("ft_127", frame_tick, 1'b1);

    // Duty: full, then brightness 0 and 1.
    count_frame();
    chk_counts("bright3", 15, 15, 15, 15);
    brightness = 2'd0;
    count_frame();
    chk_counts("bright0", 3, 3, 3, 3);
    brightness = 2'd1;
    count_frame();
    chk_counts("bright1", 7, 7, 7, 7);
    goto(327);
    chk_pins("b1_cnt7", 4'hE, 7'h40, 1'b1);
    adv(1);
    chk_pins("b1_cnt8", 4'hF, 7'h7F, 1'b1);
    goto(383);
    brightness = 2'd3;

    // Blink on digit 0; takes effect from frame 7 (phase 1 in frames 6-7, 10-11).
    goto(400);
    blink = 4'b0001;
    load = 1'b1;
    adv(1);
    load = 1'b0;
    goto(449);
    chk_pins("blink_f7_d0", 4'hF, 7'h7F, 1'b1);
    goto(465);
    chk_pins("blink_f7_d1", 4'hD, 7'h79, 1'b1);
    goto(513);
    chk_pins("blink_f8_d0", 4'hE, 7'h40, 1'b1);
    goto(577);
    chk_pins("blink_f9_d0", 4'hE, 7'h40, 1'b1);
    goto(703);
    count_frame();
    chk_counts("blink_f11", 0, 15, 15, 15);
    goto(769);
    chk_pins("blink_f12_d0", 4'hE, 7'h40, 1'b1);

    // Load in the frame-boundary cycle goes straight to the display.
    goto(830);
    glyph = {7'h12, 7'h02, 7'h78, 7'h00};
    dp_in = 4'b0100;
    blink = 4'b0000;
    load = 1'b1;
    adv(1);
    load = 1'b0;
    chk("coinc_ft", frame_tick, 1'b1);
    chk_pins("coinc_old", 4'h7, 7'h30, 1'b1);
    goto(833);
    chk_pins("coinc_d0", 4'hE, 7'h00, 1'b1);
    goto(849);
    chk_pins("coinc_d1", 4'hD, 7'h78, 1'b1);

    // Stage a load that the upcoming reset must discard.
    goto(860);
    glyph = '0;
    dp_in = 4'b1111;
    load = 1'b1;
    adv(1);
    load = 1'b0;
    goto(864);
    chk_pins("dp_guard", 4'hF, 7'h7F, 1'b1);
    adv(1);
    chk_pins("dp_d2", 4'hB, 7'h02, 1'b0);
    adv(1);
    chk_pins("pre_rst", 4'hB, 7'h02, 1'b0);

    // Reset in the middle of digit 2.
    rst = 1'b1;
    adv(1);
    chk_pins("mid_rst", 4'hF, 7'h7F, 1'b1);
    chk("mid_rst_ft", frame_tick, 1'b0);
    rst = 1'b0;
    t = -1;
    adv(1);
    chk_pins("rr_guard", 4'hF, 7'h7F, 1'b1);
    adv(1);
    chk_pins("rr_d0", 4'hE, 7'h7F, 1'b1);
    goto(17);
    chk_pins("rr_d1", 4'hD, 7'h7F, 1'b1);
    goto(63);
    chk("rr_ft63", frame_tick, 1'b1);
    goto(65);
    chk_pins("rr_discard", 4'hE, 7'h7F, 1'b1);
    goto(126);
    chk("rr_ft126", frame_tick, 1'b0);
    adv(1);
    chk("rr_ft127", frame_tick, 1'b1);

    chk("one_anode", multi_low, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
